// File: rtl/mux_scan_ctrl.sv
// Scan controller for a dual 4-to-1 mux: steps sel through a..d, settles, samples, packs an 8-bit word.
// Optional change pulse on chg is built only when MUX_SCAN_CHG_EN is defined.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CW            = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [1:0] mux_out,
  output logic [1:0] sel,
  output logic       str,
  output logic       busy,
  output logic [7:0] data,
  output logic       valid,
  output logic       chg
);

  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    shadow_q, shadow_d;
  logic          finish_c;
  logic [7:0]    scan_c;
  logic [1:0]    sel_d;
  logic          str_d, busy_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state, channel walk and per-channel sampling
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          k_d     = 2'd0;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (k_q)
            2'd0: shadow_d[1:0] = mux_out;
            2'd1: shadow_d[3:2] = mux_out;
            2'd2: shadow_d[5:4] = mux_out;
            default: ;
          endcase
          if (k_q == 2'd3) begin
            finish_c = 1'b1;
            state_d  = DONE;
            k_d      = 2'd0;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        k_d     = 2'd0;
        cnt_d   = '0;
        state_d = cont ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mux-facing outputs decoded from the upcoming state so they register cleanly
  always_comb begin
    sel_d  = (state_d == SETTLE) ? k_d : 2'd0;
    str_d  = (state_d != SETTLE);
    busy_d = (state_d != IDLE);
  end

  // Channel d goes straight into the word; a..c come from the shadow
  assign scan_c = {mux_out, shadow_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= 2'd0;
      str   <= 1'b1;
      busy  <= 1'b0;
      data  <= 8'h00;
      valid <= 1'b0;
    end else begin
      sel   <= sel_d;
      str   <= str_d;
      busy  <= busy_d;
      valid <= finish_c;
      if (finish_c) data <= scan_c;
    end
  end

`ifdef MUX_SCAN_CHG_EN
  // data still holds the previous word at the finishing edge, so it is the comparison register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg <= 1'b0;
    else        chg <= finish_c && (scan_c != data);
  end
`else
  assign chg = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: behavioural dual-mux model, scoreboard of expected scan words.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CHG_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, cont0 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
  logic [1:0] chan0 [4];
  logic [1:0] chan1 [4];
  logic [1:0] mux0, mux1, sel0, sel1;
  logic       str0, busy0, valid0, chg0, str1, busy1, valid1, chg1;
  logic [7:0] data0, data1;

  // Mux model: strobe high forces both sections to 0
  assign mux0 = str0 ? 2'b00 : chan0[sel0];
  assign mux1 = str1 ? 2'b00 : chan1[sel1];

  mux_scan_ctrl #(.SETTLE_CYCLES(2), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .mux_out(mux0),
    .sel(sel0), .str(str0), .busy(busy0), .data(data0), .valid(valid0), .chg(chg0));

  mux_scan_ctrl #(.SETTLE_CYCLES(1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .mux_out(mux1),
    .sel(sel1), .str(str1), .busy(busy1), .data(data1), .valid(valid1), .chg(chg1));

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] prev0 = 8'h00;

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  // Counts edges until valid0 is seen; -1 if the budget runs out
  task automatic wait_valid0(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (valid0) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard pop: compare the word and change flag produced on this valid cycle
  task automatic sb_pop0(input string name);
    logic [7:0] e;
    logic       ec;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: valid with data=%h but scoreboard empty", name, data0);
    end else begin
      e  = exp_q.pop_front();
      ec = CHG_EN && (e != prev0);
      prev0 = e;
      if (data0 !== e || chg0 !== ec) begin
        n_fail++;
        $display("FAIL %s: data=%h chg=%b, required data=%h chg=%b", name, data0, chg0, e, ec);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    chan0 = '{2'd3, 2'd2, 2'd1, 2'd0};
    chan1 = '{2'd0, 2'd1, 2'd2, 2'd3};
    #12;
    n_tests++;
    if ({sel0, str0, busy0, data0, valid0, chg0} !== {2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset0: sel=%0d str=%b busy=%b data=%h valid=%b chg=%b, required 0 1 0 00 0 0",
               sel0, str0, busy0, data0, valid0, chg0);
    end
    n_tests++;
    if ({sel1, str1, busy1, data1, valid1, chg1} !== {2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset1: sel=%0d str=%b busy=%b data=%h, required 0 1 0 00", sel1, str1, busy1, data1);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_q.push_back(8'h1B);
    pulse0();
    n_tests++;
    if (sel0 !== 2'd0 || str0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_enter: sel=%0d str=%b busy=%b, required 0 0 1", sel0, str0, busy0);
    end
    for (int j = 1; j < 8; j++) begin
      @(posedge clk); #1;
      n_tests++;
      if (sel0 !== 2'(j / 2) || str0 !== 1'b0 || valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_step%0d: sel=%0d str=%b valid=%b, required %0d 0 0", j, sel0, str0, valid0, j / 2);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (valid0 !== 1'b1 || busy0 !== 1'b1 || str0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: valid=%b busy=%b str=%b, required 1 1 1", valid0, busy0, str0);
    end
    if (valid0) sb_pop0("single_word");
    @(posedge clk); #1;
    n_tests++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || str0 !== 1'b1 || chg0 !== 1'b0 || data0 !== 8'h1B) begin
      n_fail++;
      $display("FAIL single_idle: valid=%b busy=%b str=%b chg=%b data=%h, required 0 0 1 0 1b",
               valid0, busy0, str0, chg0, data0);
    end
  endtask

  task automatic test_cont();
    int n;
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    cont0 = 1'b1;
    pulse0();
    wait_valid0(n);
    n_tests++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL cont_latency: %0d edges, required 8", n);
    end
    sb_pop0("cont_scan1");
    for (int s = 2; s <= 4; s++) begin
      if (s == 3) chan0 = '{2'd0, 2'd0, 2'd0, 2'd0};
      @(posedge clk); #1;
      n_tests++;
      if (str0 !== 1'b0 || busy0 !== 1'b1 || valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_gap%0d: str=%b busy=%b valid=%b, required 0 1 0", s, str0, busy0, valid0);
      end
      if (s == 4) begin
        repeat (3) @(posedge clk);
        cont0 = 1'b0;
        wait_valid0(n);
        n = n + 3;
      end else begin
        wait_valid0(n);
      end
      n_tests++;
      if (n != 8) begin
        n_fail++;
        $display("FAIL cont_period%0d: %0d edges after restart, required 8", s, n);
      end
      sb_pop0("cont_scan");
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy0 !== 1'b0 || str0 !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_stop: busy=%b str=%b, required 0 1", busy0, str0);
    end
    chan0 = '{2'd3, 2'd2, 2'd1, 2'd0};
  endtask

  task automatic test_start_ignored();
    int n;
    int extra;
    exp_q.push_back(8'h1B);
    pulse0();
    repeat (3) @(posedge clk);
    pulse0();
    wait_valid0(n);
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL ignore_latency: %0d edges after second start, required 4", n);
    end
    sb_pop0("ignore_word");
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid0) extra++;
    end
    n_tests++;
    if (extra != 0 || data0 !== 8'h1B || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_extra: %0d extra valids data=%h busy=%b, required 0 1b 0", extra, data0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    pulse0();
    seen = 0;
    for (int i = 0; i < 20 && sel0 !== 2'd2; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (sel0 !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_reach: sel=%0d, required 2", sel0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (str0 !== 1'b1 || data0 !== 8'h00 || busy0 !== 1'b0 || valid0 !== 1'b0 || sel0 !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: str=%b data=%h busy=%b valid=%b sel=%0d, required 1 00 0 0 0",
               str0, data0, busy0, valid0, sel0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    prev0 = 8'h00;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid0) seen++;
    end
    n_tests++;
    if (seen != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_novalid: %0d valids, %0d queued, required 0 0", seen, exp_q.size());
    end
    exp_q.push_back(8'h1B);
    pulse0();
    wait_valid0(n);
    n_tests++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL rstmid_restart: %0d edges, required 8", n);
    end
    sb_pop0("rstmid_word");
  endtask

  task automatic test_settle1();
    int n;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid1) begin
        n = i;
        break;
      end
    end
    n_tests++;
    if (n != 4 || data1 !== 8'hE4 || chg1 !== CHG_EN) begin
      n_fail++;
      $display("FAIL settle1: %0d edges data=%h chg=%b, required 4 e4 %b", n, data1, chg1, CHG_EN);
    end
    @(posedge clk); #1;
    n_tests++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 8'hE4) begin
      n_fail++;
      $display("FAIL settle1_idle: valid=%b busy=%b data=%h, required 0 0 e4", valid1, busy1, data1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_start_ignored();
    test_reset_mid();
    test_settle1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream/downstream companion for the SN74XX153 dual 4-to-1 mux model.
- Drives the mux select and strobe through all four channels and waits a programmable settle time on each.
- Samples the 2-bit mux output for each channel and assembles one 8-bit scan word.
- Single-shot or continuous scanning, with a one-cycle valid pulse per completed scan.

Parameters:
SETTLE_CYCLES, 2, clocks each channel is held enabled before sampling; legal range 1..15
CW, 4, width of internal settle counter; must satisfy 2**CW > SETTLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; sampled in IDLE only, begins a scan
cont  input  1  continuous mode; sampled at end of each scan
mux_out  input  2  output of the dual mux (bit1 = section 2, bit0 = section 1)
sel  output  2  mux channel select (0=a, 1=b, 2=c, 3=d)
str  output  1  mux strobe, active-high disable (1 forces mux out to 0)
busy  output  1  high in SETTLE and DONE
data  output  8  last completed scan word
valid  output  1  one-cycle pulse, data updated
chg  output  1  change pulse (see Optional Feature)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, sel=0, str=1, busy=0, data=8'h00, valid=0, chg=0, channel index k=0, cnt=0, shadow=0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Outputs: str=1, sel=0, busy=0.
  - start=1 at an edge -> SETTLE, k=0, cnt=0.
- SETTLE:
  - Outputs: str=0, sel=k, busy=1.
  - Each edge increments cnt.
  - At the edge where cnt==SETTLE_CYCLES-1, capture mux_out into shadow[2k+1:2k].
  - If k<3: k<=k+1, cnt<=0, remain in SETTLE. sel changes only at this channel-boundary edge.
  - If k==3: at the same edge, data<={mux_out, shadow[5:0]}, valid<=1, go to DONE.
- DONE, exactly one cycle:
  - Outputs: str=1, busy=1, valid=1.
  - Next edge: valid<=0. If cont=1 -> SETTLE with k=0, cnt=0; else -> IDLE.
- Latency:
  - valid rises 4*SETTLE_CYCLES edges after the edge that sampled start.
  - In continuous mode the scan period is 4*SETTLE_CYCLES+1 clocks.
- Data mapping: data[1:0]=channel a, [3:2]=b, [5:4]=c, [7:6]=d.
- start asserted outside IDLE is ignored; it is not queued.
- cont deasserted mid-scan: the current scan completes, then the block returns to IDLE.
- data holds its value between valid pulses. No partial scan ever reaches data.
- SETTLE_CYCLES=1: each channel is sampled at the first edge after sel is applied.
- Reset mid-scan: immediate return to reset values. No valid is produced; data clears to 0.

Optional Feature:
MUX_SCAN_CHG_EN
- Defined:
  - chg pulses high for exactly the valid cycle when the new data differs from the previous data.
  - The first scan after reset compares against 8'h00.
  - The comparison register resets to 0.
- Undefined: chg is tied to 0. No comparison register is built; the port remains present.

Test Plan:
- SN74XX153 model attached, a=3 b=2 c=1 d=0, SETTLE_CYCLES=2, start pulsed 1 cycle, cont=0 -> sel steps 0,1,2,3 for 2 clocks each with str=0; valid high 8 edges after start; data=8'h1B; then IDLE, str=1, busy=0.
- Same setup, cont=1 held -> valid pulses every 9 clocks, data=8'h1B each time; str=1 for exactly one cycle between scans. Drop cont mid-scan -> the current scan completes, then IDLE.
- start pulsed again during SETTLE -> ignored; exactly one valid pulse. data unchanged at 8'h1B after the pulse.
- rst_n low at channel c of a scan -> outputs asynchronously at reset values (str=1, data=0, busy=0); no valid; a new start then gives 8'h1B normally.
- SETTLE_CYCLES=1, a=0 b=1 c=2 d=3 -> valid 4 edges after start, data=8'hE4.
- MUX_SCAN_CHG_EN defined, cont=1, inputs changed from 3/2/1/0 to 0/0/0/0 between scans -> chg=1 on the first scan (8'h1B vs 0); chg=0 on repeated 8'h1B scans; chg=1 on the 8'h00 scan; chg stays 0 with the macro undefined.
